// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, direction codes and default game parameters
package game_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHOW, JUDGE, GAP, DONE} state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int WINDOW_TICKS_DEF = 3;
  localparam int MAX_ROUNDS_DEF = 16;
  localparam int LIVES_INIT_DEF = 3;
endpackage

// File: rtl/round_timer.sv
// round_timer: tick-driven response window down-counter with expiry pulse
module round_timer #(
  parameter int WINDOW_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       tick,
  input  logic       hold,
  output logic [3:0] window_left,
  output logic       expire
);
  logic [3:0] left_q, left_d;
  logic       dec;
  always_comb begin
    dec = tick && !hold && left_q != 4'd0;
    expire = dec && left_q == 4'd1;
    left_d = load ? 4'(WINDOW_TICKS) : dec ? left_q - 4'd1 : left_q;
  end
  always_ff @(posedge clk) left_q <= rst ? 4'd0 : left_d;
  assign window_left = left_q;
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: up/down reaction game round controller (ROM fetch, window timing, scoring)
module round_sequencer
  import game_pkg::*;
#(
  parameter int ADDR_W = 2,
  parameter int WINDOW_TICKS = WINDOW_TICKS_DEF,
  parameter int MAX_ROUNDS = MAX_ROUNDS_DEF,
  parameter int LIVES_INIT = LIVES_INIT_DEF,
  parameter int SCORE_W = 8
) (
  input  logic              Clk100M,
  input  logic              reset,
  input  logic              tick1Hz,
  input  logic              upB,
  input  logic              downB,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data,
  output logic              target_valid,
  output logic              target_dir,
  output logic [3:0]        window_left,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]        lives,
  output logic [7:0]        round_cnt,
  output logic              hit,
  output logic              miss,
  output logic              game_over
);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                dir_q, dir_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [2:0]          lives_q, lives_d;
  logic [7:0]          round_q, round_d;
  logic                hit_q, hit_d, miss_q, miss_d;
  logic                press, good, expire, last;
  round_timer #(.WINDOW_TICKS(WINDOW_TICKS)) u_timer (
    .clk(Clk100M),
    .rst(reset),
    .load(state_q == WAIT),
    .tick(tick1Hz),
    .hold(state_q != SHOW || press),
    .window_left(window_left),
    .expire(expire)
  );
  always_comb begin
    press = upB || downB;
    good = (upB ^ downB) && ((upB ? DIR_UP : DIR_DOWN) == dir_q);
    last = lives_q == 3'd0 || round_q + 8'd1 == 8'(MAX_ROUNDS);
    hit_d = state_q == SHOW && press && good;
    miss_d = state_q == SHOW && (press || expire) && !hit_d;
    score_d = hit_d && score_q != '1 ? score_q + SCORE_W'(1) : score_q;
    lives_d = miss_d && lives_q != 3'd0 ? lives_q - 3'd1 : lives_q;
    round_d = state_q == JUDGE ? round_q + 8'd1 : round_q;
    addr_d = state_q == JUDGE ? addr_q + ADDR_W'(1) : addr_q;
    dir_d = state_q == WAIT ? rom_data : dir_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = press ? FETCH : IDLE;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = SHOW;
      SHOW:    state_d = press || expire ? JUDGE : SHOW;
      JUDGE:   state_d = last ? DONE : GAP;
      GAP:     state_d = tick1Hz ? FETCH : GAP;
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge Clk100M) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      dir_q <= 1'b0;
      score_q <= '0;
      lives_q <= 3'(LIVES_INIT);
      round_q <= 8'd0;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      dir_q <= dir_d;
      score_q <= score_d;
      lives_q <= lives_d;
      round_q <= round_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
    end
  end
  assign rom_addr = addr_q;
  assign target_valid = state_q == SHOW;
  assign target_dir = dir_q;
  assign score = score_q;
  assign lives = lives_q;
  assign round_cnt = round_q;
  assign hit = hit_q;
  assign miss = miss_q;
  assign game_over = state_q == DONE;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: table-driven and randomized round-level checks of round_sequencer
module tb_round_sequencer;
  localparam int W = 3;
  localparam int MAXR = 16;
  localparam int LIV = 3;
  typedef struct {
    int kind;
    int tb4;
    bit wt;
    bit tgt;
    bit hit;
    bit miss;
    int score;
    int lives;
  } vec_t;
  logic clk = 0, reset = 1, tick = 0, up = 0, dn = 0;
  logic [1:0] rom_addr;
  logic rom_data, tv, tdir, hit, miss, go;
  logic [3:0] wl;
  logic [7:0] score, rc;
  logic [2:0] lives;
  logic rom_mem [4];
  int n_chk = 0, n_fail = 0;
  int m_score, m_lives, m_round, kind, r;
  bit m_done, tgt, h;
  vec_t tbl [MAXR];
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];
  round_sequencer dut (
    .Clk100M(clk), .reset(reset), .tick1Hz(tick), .upB(up), .downB(dn),
    .rom_addr(rom_addr), .rom_data(rom_data), .target_valid(tv), .target_dir(tdir),
    .window_left(wl), .score(score), .lives(lives), .round_cnt(rc),
    .hit(hit), .miss(miss), .game_over(go)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic pulse(input logic u, input logic d, input logic t);
    up = u;
    dn = d;
    tick = t;
    step();
    up = 0;
    dn = 0;
    tick = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    step();
    reset = 0;
  endtask
  task automatic check_reset();
    chk("rst_valid", tv, 0);
    chk("rst_dir", tdir, 0);
    chk("rst_window", wl, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, LIV);
    chk("rst_round", rc, 0);
    chk("rst_hit", hit, 0);
    chk("rst_miss", miss, 0);
    chk("rst_over", go, 0);
    chk("rst_addr", rom_addr, 0);
  endtask
  // Called just after the edge that leaves GAP/IDLE: FETCH, WAIT, then SHOW
  task automatic enter_round(input int e_addr);
    chk("fetch_valid", tv, 0);
    chk("fetch_addr", rom_addr, e_addr);
    step();
    chk("wait_valid", tv, 0);
    step();
  endtask
  task automatic start_game();
    pulse(0, 0, 1);
    chk("idle_tick_valid", tv, 0);
    chk("idle_tick_over", go, 0);
    pulse(1, 0, 0);
    enter_round(0);
  endtask
  // kind: 0 up, 1 down, 2 both, 3 no press (timeout)
  task automatic do_round(input int kind, input int tb4, input bit wt, input bit e_tgt,
                          input bit e_hit, input bit e_miss, input int e_score,
                          input int e_lives, input int e_round, input bit e_done,
                          input bit gap_press);
    int nt;
    nt = (kind == 3) ? W : tb4;
    chk("show_valid", tv, 1);
    chk("target_dir", tdir, e_tgt);
    for (int i = 0; i < nt; i++) begin
      idle($urandom_range(0, 2));
      chk("window_left", wl, W - i);
      pulse(0, 0, 1);
    end
    if (kind != 3) begin
      idle($urandom_range(0, 2));
      chk("window_before_press", wl, W - nt);
      pulse(kind != 1, kind != 0, wt);
    end
    chk("hit", hit, e_hit);
    chk("miss", miss, e_miss);
    step();
    chk("hit_one_cycle", hit, 0);
    chk("miss_one_cycle", miss, 0);
    chk("score", score, e_score);
    chk("lives", lives, e_lives);
    chk("round_cnt", rc, e_round);
    chk("game_over", go, e_done);
    if (e_done) begin
      pulse(1, 0, 1);
      chk("done_hit", hit, 0);
      chk("done_miss", miss, 0);
      pulse(1, 1, 0);
      idle(2);
      chk("done_hold_over", go, 1);
      chk("done_hold_score", score, e_score);
      chk("done_hold_round", rc, e_round);
      chk("done_hold_lives", lives, e_lives);
    end else begin
      if (gap_press) begin
        pulse(1, 0, 0);
        chk("gap_hit", hit, 0);
        chk("gap_miss", miss, 0);
        pulse(0, 1, 0);
        chk("gap_valid", tv, 0);
        idle(1);
        chk("gap_hit2", hit, 0);
        chk("gap_miss2", miss, 0);
        chk("gap_score", score, e_score);
        chk("gap_lives", lives, e_lives);
        chk("gap_round", rc, e_round);
      end
      idle($urandom_range(0, 2));
      pulse(0, 0, 1);
      enter_round(e_round % 4);
    end
  endtask
  initial begin
    for (int i = 0; i < MAXR; i++) begin
      tbl[i].tgt = (i % 4 == 0) || (i % 4 == 3);
      tbl[i].kind = tbl[i].tgt ? 0 : 1;
      tbl[i].tb4 = i % 3;
      tbl[i].wt = (i % 3 == 2);
      tbl[i].hit = 1;
      tbl[i].miss = 0;
      tbl[i].score = i + 1;
      tbl[i].lives = LIV;
    end
    rom_mem = '{1'b1, 1'b0, 1'b0, 1'b1};
    idle(1);
    do_reset();
    check_reset();
    start_game();
    for (int i = 0; i < MAXR; i++)
      do_round(tbl[i].kind, tbl[i].tb4, tbl[i].wt, tbl[i].tgt, tbl[i].hit, tbl[i].miss,
               tbl[i].score, tbl[i].lives, i + 1, i == MAXR - 1, i % 2 == 1);
    for (int k = 0; k < 4; k++) rom_mem[k] = 1'($urandom_range(0, 1));
    do_reset();
    check_reset();
    start_game();
    for (int i = 0; i < 3; i++)
      do_round(3, 0, 0, rom_mem[i], 0, 1, 0, LIV - 1 - i, i + 1, i == 2, 0);
    rom_mem = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    start_game();
    do_round(2, 1, 0, 1, 0, 1, 0, LIV - 1, 1, 0, 0);
    do_round(0, 0, 0, 1, 1, 0, 1, LIV - 1, 2, 0, 0);
    rom_mem = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    start_game();
    for (int i = 0; i < 5; i++)
      do_round(rom_mem[i % 4] ? 0 : 1, 0, 0, rom_mem[i % 4], 1, 0, i + 1, LIV, i + 1, 0, 0);
    chk("pre_reset_score", score, 5);
    chk("pre_reset_valid", tv, 1);
    reset = 1;
    up = 1;
    tick = 1;
    step();
    reset = 0;
    up = 0;
    tick = 0;
    check_reset();
    idle(2);
    chk("idle_after_reset", tv, 0);
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 4; k++) rom_mem[k] = 1'($urandom_range(0, 1));
      do_reset();
      start_game();
      m_score = 0;
      m_lives = LIV;
      m_round = 0;
      m_done = 0;
      while (!m_done && m_round < 40) begin
        tgt = rom_mem[m_round % 4];
        r = $urandom_range(0, 9);
        kind = r < 7 ? (tgt ? 0 : 1) : r == 7 ? (tgt ? 1 : 0) : r == 8 ? 2 : 3;
        h = (kind == 0 && tgt) || (kind == 1 && !tgt);
        if (h) m_score = m_score == 255 ? 255 : m_score + 1;
        else if (m_lives > 0) m_lives--;
        m_round++;
        m_done = m_lives == 0 || m_round == MAXR;
        do_round(kind, $urandom_range(0, W - 1), 1'($urandom_range(0, 1)), tgt, h, !h,
                 m_score, m_lives, m_round, m_done, 1'($urandom_range(0, 1)));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
